// File: rtl/octave_decimator_pkg.sv
// rtl/octave_decimator_pkg.sv - shared constants and types for the octave decimator
package octave_decimator_pkg;

   localparam logic [7:0] BLANK_PIXEL = 8'h00;
   localparam logic [9:0] ROUND_CONST = 10'd2;

   typedef struct packed {
      logic       blank;
      logic [8:0] sum;
   } pair_t;

   function automatic logic [7:0] round_quad(input logic [9:0] sum);
      logic [9:0] rounded;
      rounded = sum + ROUND_CONST;
      return rounded[9:2];
   endfunction

endpackage

// File: rtl/octave_decimator_if.sv
// rtl/octave_decimator_if.sv - pixel stream in/out bundle for the octave decimator
interface octave_decimator_if;
   logic [7:0] din;
   logic       blanking_in;
   logic       validin;
   logic [7:0] dout;
   logic       blanking_out;
   logic       validout;

   modport master (
      output din, blanking_in, validin,
      input  dout, blanking_out, validout
   );

   modport slave (
      input  din, blanking_in, validin,
      output dout, blanking_out, validout
   );
endinterface

// File: rtl/octave_decimator_half_row_buffer.sv
// rtl/octave_decimator_half_row_buffer.sv - line store of horizontal pair sums from the even row
import octave_decimator_pkg::*;

module half_row_buffer #(
   parameter int entries = 210,
   parameter int aw      = 8
) (
   input  logic          clock,
   input  logic          we,
   input  logic [aw-1:0] waddr,
   input  pair_t         wdata,
   input  logic [aw-1:0] raddr,
   output pair_t         rdata
);

   // No reset: entries are always written in the even row before being read.
   pair_t mem [entries];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   // Combinational read so the pair sum is available on the odd-column cycle itself.
   assign rdata = mem[raddr];

endmodule

// File: rtl/octave_decimator.sv
// rtl/octave_decimator.sv - 2x2 averaging decimator producing a half-resolution stream
import octave_decimator_pkg::*;

module octave_decimator #(
   parameter int width = 420
) (
   input logic                clock,
   input logic                reset,
   octave_decimator_if.slave  pix
);

   localparam int XW = $clog2(width);
   localparam int AW = XW - 1;

   logic [XW-1:0] x_count;
   logic          odd_row;
   logic [7:0]    left_pix;
   logic          left_blank;

   logic          odd_col;
   logic          buf_we;
   pair_t         wr_pair;
   pair_t         rd_pair;
   logic [9:0]    quad_sum;
   logic          quad_blank;

   assign odd_col = x_count[0];
   assign buf_we  = pix.validin && !reset && !odd_row && odd_col;

   assign wr_pair.sum   = {1'b0, left_pix} + {1'b0, pix.din};
   assign wr_pair.blank = left_blank | pix.blanking_in;

   assign quad_sum   = {2'b00, left_pix} + {2'b00, pix.din} + {1'b0, rd_pair.sum};
   assign quad_blank = left_blank | pix.blanking_in | rd_pair.blank;

   half_row_buffer #(
      .entries (width / 2),
      .aw      (AW)
   ) u_line (
      .clock (clock),
      .we    (buf_we),
      .waddr (x_count[XW-1:1]),
      .wdata (wr_pair),
      .raddr (x_count[XW-1:1]),
      .rdata (rd_pair)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         x_count          <= '0;
         odd_row          <= 1'b0;
         left_pix         <= 8'h00;
         left_blank       <= 1'b0;
         pix.dout         <= BLANK_PIXEL;
         pix.blanking_out <= 1'b0;
         pix.validout     <= 1'b0;
      end else begin
         pix.validout <= 1'b0;
         if (pix.validin) begin
            if (x_count == XW'(width - 1)) begin
               x_count <= '0;
               odd_row <= ~odd_row;
            end else begin
               x_count <= x_count + 1'b1;
            end
            // The left pixel of each pair is held on both row types.
            if (!odd_col) begin
               left_pix   <= pix.din;
               left_blank <= pix.blanking_in;
            end
            if (odd_row && odd_col) begin
               pix.validout     <= 1'b1;
               pix.blanking_out <= quad_blank;
               pix.dout         <= quad_blank ? BLANK_PIXEL : round_quad(quad_sum);
            end
         end
      end
   end

endmodule

// File: tb/tb_octave_decimator.sv
// tb/tb_octave_decimator.sv - scoreboard bench for the octave decimator against a 2x2 average model
module tb_octave_decimator;

   localparam int W = 4;
   localparam int MAXR = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   octave_decimator_if bus();

   octave_decimator #(.width(W)) dut (
      .clock (clock),
      .reset (reset),
      .pix   (bus.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] d;
      logic       b;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   strobes = 0;
   int   exp_strobes = 0;
   logic [7:0] last_dout = 8'h00;
   logic       last_blank = 1'b0;

   logic [7:0] fp [MAXR][W];
   logic       fb [MAXR][W];

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on every strobe, checks hold between strobes.
   always @(negedge clock) begin
      if (reset) begin
         last_dout  = 8'h00;
         last_blank = 1'b0;
      end else if (bus.validout) begin
         strobes++;
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("dout", int'(bus.dout), int'(e.d));
            check("blanking_out", int'(bus.blanking_out), int'(e.b));
         end
         last_dout  = bus.dout;
         last_blank = bus.blanking_out;
      end else begin
         if (bus.dout !== last_dout || bus.blanking_out !== last_blank)
            check("hold_between_strobes", int'({bus.blanking_out, bus.dout}),
                  int'({last_blank, last_dout}));
      end
   end

   // Reference: each output is the rounded mean of a 2x2 block, zero if any pixel blanks.
   task automatic push_expected(input int rows);
      for (int r = 0; r + 1 < rows; r += 2)
         for (int c = 0; c < W; c += 2) begin
            exp_t e;
            int s;
            s   = fp[r][c] + fp[r][c+1] + fp[r+1][c] + fp[r+1][c+1];
            e.b = fb[r][c] | fb[r][c+1] | fb[r+1][c] | fb[r+1][c+1];
            e.d = e.b ? 8'd0 : 8'((s + 2) / 4);
            exp_q.push_back(e);
            exp_strobes++;
         end
   endtask

   task automatic fill(input int v);
      for (int r = 0; r < MAXR; r++)
         for (int c = 0; c < W; c++) begin
            fp[r][c] = 8'(v);
            fb[r][c] = 1'b0;
         end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic b);
      bus.validin     = v;
      bus.din         = d;
      bus.blanking_in = b;
      tick();
   endtask

   // gap_mode: 0 none, 1 two idle cycles after each pixel, 2 random 0..3 idles
   task automatic send_pixels(input int rows, input int last_col, input int gap_mode);
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < W; c++) begin
            if (r == rows - 1 && c > last_col) return;
            drive(1'b1, fp[r][c], fb[r][c]);
            if (gap_mode == 1) begin
               drive(1'b0, 8'($urandom), 1'($urandom));
               drive(1'b0, 8'($urandom), 1'($urandom));
            end else if (gap_mode == 2) begin
               int g;
               g = $urandom_range(0, 3);
               for (int k = 0; k < g; k++) drive(1'b0, 8'($urandom), 1'($urandom));
            end
         end
      bus.validin = 1'b0;
   endtask

   task automatic send_frame(input int rows, input int gap_mode);
      push_expected(rows);
      send_pixels(rows, W - 1, gap_mode);
   endtask

   initial begin
      bus.validin     = 1'b0;
      bus.din         = 8'h00;
      bus.blanking_in = 1'b0;
      reset = 1'b1;
      // Reset takes priority over a simultaneous valid pixel.
      bus.validin = 1'b1;
      bus.din     = 8'd77;
      repeat (3) tick();
      bus.validin = 1'b0;
      check("reset_dout", int'(bus.dout), 0);
      check("reset_blanking_out", int'(bus.blanking_out), 0);
      check("reset_validout", int'(bus.validout), 0);
      reset = 1'b0;
      tick();

      fill(100);
      send_frame(4, 0);

      fill(0);
      fp[0][0] = 8'd10; fp[0][1] = 8'd20; fp[1][0] = 8'd30; fp[1][1] = 8'd41;
      send_frame(2, 0);

      fill(255);
      send_frame(4, 0);

      fill(50);
      fb[1][2] = 1'b1;
      send_frame(4, 0);

      fill(100);
      send_frame(4, 1);

      // Interrupted frame: row 0 and row 1 column 0 sent, reset at row 1 column 1.
      fill(80);
      send_pixels(2, 0, 0);
      reset = 1'b1;
      drive(1'b1, 8'd80, 1'b0);
      check("midreset_validout", int'(bus.validout), 0);
      reset = 1'b0;
      send_frame(4, 0);

      for (int f = 0; f < 20; f++) begin
         int rows;
         rows = 2 * $urandom_range(1, MAXR / 2);
         for (int r = 0; r < MAXR; r++)
            for (int c = 0; c < W; c++) begin
               fp[r][c] = 8'($urandom);
               fb[r][c] = ($urandom_range(0, 15) == 0);
            end
         send_frame(rows, $urandom_range(0, 2));
      end

      repeat (5) tick();
      check("strobe_count", strobes, exp_strobes);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/octave_decimator.md
OCTAVE_DECIMATOR -- requirements
Module: octave_decimator

Interface
REQ-001 SHALL have parameter: width, 420, input line width in pixels; even, >= 4; output line width = width/2.
REQ-002 SHALL have port: clock  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: din  input  8  blurred pixel from the 5x5 window stage, raster order.
REQ-005 SHALL have port: blanking_in  input  1  pixel is blanking; qualified by validin.
REQ-006 SHALL have port: validin  input  1  din/blanking_in valid this cycle; no backpressure.
REQ-007 SHALL have port: dout  output  8  averaged 2x2 pixel of half-resolution stream.
REQ-008 SHALL have port: blanking_out  output  1  output pixel is blanking.
REQ-009 SHALL have port: validout  output  1  one-cycle strobe qualifying dout/blanking_out.

Function
REQ-010 SHALL keep x_count (0..width-1) and row parity; both advance only on validin; x_count wraps to 0 after width-1, toggling parity.
REQ-011 SHALL ignore din/blanking_in entirely in cycles with validin low; gaps of any length SHALL NOT change results.
REQ-012 SHALL, on even rows, odd columns, write the 9-bit pair sum (previous pixel + din) and the OR of both blanking flags into buffer address x_count>>1.
REQ-013 SHALL, on odd rows, even columns, register din and blanking_in as the held left pixel.
REQ-014 SHALL, on odd rows, odd columns, form a 10-bit sum = held left + din + buffered pair sum at address x_count>>1.
REQ-015 SHALL compute dout = (sum + 2) >> 2, round half up; max result is 255, no saturation needed.
REQ-016 SHALL set blanking_out = OR of the four contributing blanking flags; dout SHALL be 8'h00 whenever blanking_out is 1.
REQ-017 SHALL assert validout exactly one cycle after the validin cycle carrying the odd-row/odd-column pixel, for exactly one cycle.
REQ-018 SHALL hold dout and blanking_out stable between validout strobes.
REQ-019 SHALL produce exactly width/2 strobes per odd row and none on even rows.
REQ-020 SHALL treat the cycle after row width-1 on an odd row as even row, column 0, with no lost or extra strobe.
REQ-021 SHALL read each buffer entry only after it was written in the preceding even row; unwritten contents are don't-care.

Reset
REQ-022 SHALL, while reset is high, set x_count=0, parity=even, dout=8'h00, blanking_out=0, validout=0, held left pixel=0.
REQ-023 SHALL NOT reset buffer contents.
REQ-024 SHALL, on a reset asserted mid-frame, treat the first validin after release as even row, column 0; no strobe from the interrupted row pair.
REQ-025 SHALL give reset priority over validin in the same cycle.

Structure
REQ-026 SHALL place the blanking pixel value (8'h00) and the rounding constant (2) in the shared constants include used by the window stages.
REQ-027 SHALL implement the line store as one sub-module, half_row_buffer: width/2 entries x 10 bits (9-bit sum + blanking).
REQ-028 SHALL give the buffer a synchronous write port and a read port whose data is usable on the odd-column cycle.
REQ-029 SHALL size x_count as $clog2(width) bits.

Verification
REQ-030 SHALL check, with width=4, a 4x4 frame of constant 100 and validin always high: 4 strobes total, 2 per odd row, each dout=100, blanking_out=0.
REQ-031 SHALL check, with width=4, block 10,20 / 30,41: sum 101, dout=(101+2)>>2=25.
REQ-032 SHALL check an all-255 frame: every dout=255, no wrap to 0.
REQ-033 SHALL check a frame of 50 with blanking_in=1 on one pixel (row 1, col 2): the covering output has dout=0, blanking_out=1; all others are 50 with blanking_out=0.
REQ-034 SHALL check that REQ-030 stimulus with validin toggling 1,0,0,1,... gives identical dout sequence and strobe count.
REQ-035 SHALL check that reset pulsed at row 1, column 1 followed by a fresh 4x4 frame of 80 gives no strobe before row 1 of the new frame, then 2 strobes per odd row of dout=80.
